// File: rtl/encoder_fec_pkg.sv
`default_nettype none
// ============================================================================
// Package  : encoder_fec_pkg
// Brief    : Shared types and widths for the FEC encoder scheduler slice.
// Revision : 1.0 - initial release
// ============================================================================
package encoder_fec_pkg;

    localparam int MSG_W = 8;
    localparam int ENC_W = 16;

    typedef logic [MSG_W-1:0] message_data_t;
    typedef logic [ENC_W-1:0] encoded_message_data_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    // Index width for n clients; a single client still gets a 1-bit id.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fec_encoder_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin arbiter, combinational grant, registered pointer.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import encoder_fec_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_W = id_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_advance,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_idx,
    output logic               o_grant_valid
);

    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] w_cand [NUM_REQ];
    logic [ID_W-1:0] w_next_ptr;

    // Candidate k is the client k positions after the pointer, wrapped once.
    generate
        for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
            logic [ID_W:0] w_sum;
            assign w_sum     = {1'b0, r_ptr} + (ID_W+1)'(k);
            assign w_cand[k] = (w_sum >= (ID_W+1)'(NUM_REQ))
                             ? ID_W'(w_sum - (ID_W+1)'(NUM_REQ))
                             : ID_W'(w_sum);
        end
    endgenerate

    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req[w_cand[k]]) begin
                o_grant_valid = 1'b1;
                o_grant_idx   = w_cand[k];
            end
        end
        o_grant = o_grant_valid ? (NUM_REQ'(1) << o_grant_idx) : '0;
    end

    assign w_next_ptr = (o_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : o_grant_idx + ID_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_advance && o_grant_valid) begin
            r_ptr <= w_next_ptr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fec_encoder_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fec_encoder_scheduler
// Brief    : Round-robin sharing of one FEC encoder among NUM_REQ clients.
//            The encoder's own reset is active-low and is driven with ~rst.
// Revision : 1.0 - initial release
// ============================================================================
module fec_encoder_scheduler
    import encoder_fec_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 4,
    localparam int ID_W = id_width(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       cli_valid,
    input  logic [NUM_REQ*MSG_W-1:0] cli_data,
    output logic [NUM_REQ-1:0]       cli_ready,
    output logic                     enc_en,
    output logic                     enc_req,
    output logic [MSG_W-1:0]         enc_data_in,
    input  logic                     enc_ack,
    input  logic [ENC_W-1:0]         enc_data_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ENC_W-1:0]         out_data,
    output logic [ID_W-1:0]          out_id,
    output logic                     timeout_err,
    output logic                     busy
);

    localparam logic [1:0] c_ST_IDLE  = IDLE;
    localparam logic [1:0] c_ST_ISSUE = ISSUE;
    localparam logic [1:0] c_ST_WAIT  = WAIT;
    localparam logic [1:0] c_ST_RESP  = RESP;

    localparam int c_CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]            r_state;
    message_data_t         r_msg;
    logic [ID_W-1:0]       r_id;
    encoded_message_data_t r_out_data;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_timeout_err;

    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_W-1:0]       w_grant_idx;
    logic                  w_grant_valid;
    logic                  w_idle;
    message_data_t         w_cli_msg [NUM_REQ];

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_cli_msg
            assign w_cli_msg[i] = cli_data[MSG_W*i +: MSG_W];
        end
    endgenerate

    assign w_idle = (r_state == c_ST_IDLE);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk           (clk),
        .rst           (rst),
        .i_req         (cli_valid),
        .i_advance     (w_idle),
        .o_grant       (w_grant),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_msg         <= '0;
            r_id          <= '0;
            r_out_data    <= '0;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_msg   <= w_cli_msg[w_grant_idx];
                        r_id    <= w_grant_idx;
                        r_state <= c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    // An ack on the last allowed cycle still beats the timeout.
                    if (enc_ack) begin
                        r_out_data <= enc_data_out;
                        r_state    <= c_ST_RESP;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                c_ST_RESP: begin
                    if (out_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign cli_ready   = (w_idle && !rst) ? w_grant : '0;
    assign enc_en      = (r_state == c_ST_ISSUE);
    assign enc_req     = (r_state == c_ST_ISSUE);
    assign enc_data_in = (r_state == c_ST_ISSUE) ? r_msg : '0;
    assign out_valid   = (r_state == c_ST_RESP);
    assign out_data    = r_out_data;
    assign out_id      = r_id;
    assign timeout_err = r_timeout_err;
    assign busy        = !w_idle;

endmodule
`default_nettype wire

// File: doc/fec_encoder_scheduler.md
Name: fec_encoder_scheduler

Overview:
Shares one FEC encoder instance (8-bit message in, 16-bit Hamming codeword out, 1-cycle registered latency, ack-qualified) among NUM_REQ clients. Round-robin arbitration picks a client, issues one encode request, captures the codeword on ack, and returns it tagged with the client ID over a valid/ready output. A timeout guards against a missing ack.

Parameters:
NUM_REQ, 4, number of requesting clients (>=1)
TIMEOUT_CYC, 4, max cycles in WAIT for enc_ack before abort (>=1)
ID_W, $clog2(NUM_REQ) min 1, width of out_id (derived localparam)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
cli_valid  in  NUM_REQ  per-client request
cli_data  in  NUM_REQ*8  per-client message; client i at [8*i+7:8*i]
cli_ready  out  NUM_REQ  one-hot accept pulse
enc_en  out  1  encoder enable
enc_req  out  1  encoder request
enc_data_in  out  8  message to encoder
enc_ack  in  1  encoder ack (codeword valid)
enc_data_out  in  16  encoder codeword
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_data  out  16  captured codeword
out_id  out  ID_W  index of originating client
timeout_err  out  1  one-cycle pulse on WAIT timeout
busy  out  1  high whenever state != IDLE

Behaviour:
- One clock; reset synchronous, active-high. On rst: state IDLE, rr pointer 0, all outputs 0, timeout counter 0. Reset mid-transaction drops it silently.
- FSM: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any cli_valid, grant first valid client at/after rr pointer (wrapping); cli_ready[g]=1 this cycle only; latch cli_data[g] and g; go ISSUE. No valid -> stay. cli_ready=0 in all other states.
- ISSUE (exactly 1 cycle): enc_en=1, enc_req=1, enc_data_in=latched message; go WAIT, counter cleared. enc_en/enc_req=0 in all other states; enc_data_in=0 outside ISSUE.
- WAIT: enc_ack=1 -> capture enc_data_out into out_data, go RESP. Else counter++; when counter reaches TIMEOUT_CYC: timeout_err=1 for one cycle, go IDLE, result discarded. Ack on the final timeout cycle wins (no error).
- RESP: out_valid=1, out_data/out_id stable. out_ready=1 -> go IDLE next cycle; out_valid low next cycle. Held indefinitely while out_ready=0; no new grant meanwhile.
- enc_ack outside WAIT ignored.
- rr pointer updated at grant: pointer = (g+1) mod NUM_REQ (also on later timeout).
- Nominal latency: accept cycle T, ISSUE T+1, ack/capture T+2, out_valid T+3. With out_ready held high: one transaction per 4 cycles.
- NUM_REQ=1: arbiter degenerates to pass-through, ID_W=1, out_id=0.

Decomposition:
- Shared package encoder_fec_pkg: message_data_t (8b), encoded_message_data_t (16b), MSG_W=8, ENC_W=16, sched_state_t enum {IDLE, ISSUE, WAIT, RESP}.
- One sub-module: rr_arbiter (NUM_REQ req vector, pointer, advance strobe -> one-hot grant + index), combinational grant, registered pointer.
- Top-level note: encoder reset is active-low; integration drives it with ~rst.

Test Plan:
- Single client 1, cli_data=8'hA5, encoder model acks next cycle, out_ready=1 -> cli_ready=4'b0010 at T, enc_req at T+1 with enc_data_in=8'hA5, out_valid at T+3 with out_data=encoder codeword for 8'hA5, out_id=1.
- All four clients valid continuously, out_ready=1 -> grant order 0,1,2,3,0; one cli_ready pulse per 4 cycles; out_ids match order.
- Encoder model never acks -> timeout_err pulse exactly TIMEOUT_CYC=4 cycles after entering WAIT; no out_valid; next grant goes to pointer+1.
- Ack arrives on 4th WAIT cycle -> out_valid asserted, timeout_err stays 0.
- out_ready=0 for 10 cycles in RESP with clients valid -> out_valid/out_data/out_id stable, cli_ready stays 0; release -> IDLE, next grant.
- rst=1 during WAIT -> next cycle all outputs 0, busy=0, rr pointer 0; late enc_ack ignored; client 0 granted first after reset.
